// File: rtl/cbus_arbiter_pkg.sv
// ============================================================================
//  Module   : cbus_arbiter_pkg
//  Purpose  : Cache-bus request/response types and burst-length decode.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cbus_arbiter_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [2:0] {
        MLEN1  = 3'd0,
        MLEN2  = 3'd1,
        MLEN4  = 3'd2,
        MLEN8  = 3'd3,
        MLEN16 = 3'd4
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        msize_t      size;
        mlen_t       len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    // Number of beats in a burst of the given encoded length.
    function automatic logic [4:0] mlen_beats(input mlen_t len);
        case (len)
            MLEN1:   return 5'd1;
            MLEN2:   return 5'd2;
            MLEN4:   return 5'd4;
            MLEN8:   return 5'd8;
            MLEN16:  return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cbus_arbiter_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker: first requester at or after
//             the pointer, scanning upward with wrap-around.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM   = 2,
    parameter int IDX_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam int c_SUM_W = IDX_W + 1;

    logic [c_SUM_W-1:0] w_sum;
    logic [IDX_W-1:0]   w_cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + c_SUM_W'(i);
            if (w_sum >= c_SUM_W'(NUM)) begin
                w_sum = w_sum - c_SUM_W'(NUM);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cbus_arbiter.sv
// ============================================================================
//  Module   : cbus_arbiter
//  Purpose  : Round-robin arbiter from the cache masters onto the single
//             memory-side cache bus; grant is held for a whole burst.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  cbus_req_t                      mreq  [NUM_MASTERS],
    output cbus_resp_t                     mresp [NUM_MASTERS],
    output cbus_req_t                      sreq,
    input  cbus_resp_t                     sresp,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           busy
);

    localparam int c_IDX_W = $clog2(NUM_MASTERS);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [c_IDX_W-1:0]     r_owner;
    logic [c_IDX_W-1:0]     w_owner_next;
    logic [c_IDX_W-1:0]     r_rr_ptr;
    logic [c_IDX_W-1:0]     w_rr_next;
    logic [4:0]             r_beat;
    logic [4:0]             w_beat_next;
    logic [NUM_MASTERS-1:0] w_req_valid;
    logic [c_IDX_W-1:0]     w_pick_idx;
    logic                   w_pick_found;
    logic                   w_owner_valid;
    logic                   w_done;

    for (genvar j = 0; j < NUM_MASTERS; j++) begin : g_master
        assign w_req_valid[j] = mreq[j].valid;
        assign mresp[j] = (r_state == c_BUSY && r_owner == c_IDX_W'(j)) ? sresp : '0;
    end

    rr_pick #(
        .NUM   (NUM_MASTERS),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .req   (w_req_valid),
        .ptr   (r_rr_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_owner_valid = mreq[r_owner].valid;
    assign w_done        = sresp.ready && sresp.last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= c_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_beat   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_rr_ptr <= w_rr_next;
            r_beat   <= w_beat_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr_ptr;
        w_beat_next  = r_beat;
        case (r_state)
            c_IDLE: begin
                w_beat_next = '0;
                if (w_pick_found) begin
                    w_state_next = c_BUSY;
                    w_owner_next = w_pick_idx;
                end
            end
            c_BUSY: begin
                // An owner abandoning its request does not earn a turn advance.
                if (!w_owner_valid) begin
                    w_state_next = c_IDLE;
                    w_beat_next  = '0;
                end else if (w_done) begin
                    w_state_next = c_IDLE;
                    w_beat_next  = '0;
                    w_rr_next    = (r_owner == c_IDX_W'(NUM_MASTERS - 1)) ?
                                   '0 : r_owner + c_IDX_W'(1);
                end else if (sresp.ready) begin
                    w_beat_next = r_beat + 5'd1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_beat_next  = '0;
            end
        endcase
    end

    always_comb begin
        busy  = (r_state == c_BUSY);
        owner = r_owner;
        sreq  = '0;
        if (r_state == c_BUSY) begin
            sreq = mreq[r_owner];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && r_state == c_BUSY) begin
            assert (w_owner_valid)
                else $error("cbus_arbiter: owner %0d dropped valid mid-transaction", r_owner);
            if (sresp.ready) begin
                assert (sresp.last == (5'(r_beat + 5'd1) == mlen_beats(mreq[r_owner].len)))
                    else $error("cbus_arbiter: last does not agree with burst length at beat %0d", r_beat);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
// ============================================================================
//  Module   : tb_cbus_arbiter
//  Purpose  : Directed bench for cbus_arbiter with a grant/response scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  mreq  [N];
    cbus_resp_t mresp [N];
    cbus_req_t  sreq;
    cbus_resp_t sresp;
    logic [0:0] owner;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    int          grant_q [$];
    cbus_resp_t  resp_q  [$];
    logic [31:0] wbeat   [4];

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mreq   (mreq),
        .mresp  (mresp),
        .sreq   (sreq),
        .sresp  (sresp),
        .owner  (owner),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic raise(input int m, input logic [31:0] addr, input logic wr,
                         input msize_t sz, input mlen_t ln, input logic [3:0] strb);
        mreq[m].valid    = 1'b1;
        mreq[m].is_write = wr;
        mreq[m].addr     = addr;
        mreq[m].size     = sz;
        mreq[m].len      = ln;
        mreq[m].strobe   = strb;
        mreq[m].data     = '0;
    endtask

    // Memory-side responder for the next expected owner; ends mid cycle M+1.
    task automatic serve(input int waits, input bit keep);
        int         m;
        int         n;
        cbus_resp_t d;
        cbus_resp_t e;
        m = grant_q.pop_front();
        n = int'(mlen_beats(mreq[m].len));
        for (int b = 0; b < n; b++) begin
            if (b > 0) begin
                for (int w = 0; w < waits; w++) begin
                    sresp = '0;
                    #1;
                    chk("wait_mresp", mresp[m], '0);
                    chk("wait_sreq_valid", sreq.valid, 1'b1);
                    cyc();
                end
            end
            if (mreq[m].is_write && b < 4) mreq[m].data = wbeat[b];
            d.ready = 1'b1;
            d.last  = (b == n - 1);
            d.data  = mreq[m].is_write ? 32'h0 : 32'hC0DE_0000 + 32'(b) + 32'(m << 8);
            sresp   = d;
            resp_q.push_back(d);
            #1;
            e = resp_q.pop_front();
            chk("mresp_owner", mresp[m], e);
            chk("mresp_other", mresp[1 - m], '0);
            chk("sreq_fwd", sreq, mreq[m]);
            chk("owner", owner, 128'(m));
            chk("busy", busy, 1'b1);
            cyc();
        end
        sresp = '0;
        if (!keep) mreq[m].valid = 1'b0;
        #1;
        chk("turn_sreq_valid", sreq.valid, 1'b0);
        chk("turn_busy", busy, 1'b0);
        chk("turn_mresp", mresp[m], '0);
    endtask

    initial begin
        resetn = 1'b0;
        for (int m = 0; m < N; m++) mreq[m] = '0;
        sresp = '0;
        wbeat[0] = 32'h11; wbeat[1] = 32'h22; wbeat[2] = 32'h33; wbeat[3] = 32'h44;
        cyc();
        cyc();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_sreq", sreq, '0);
        chk("rst_mresp0", mresp[0], '0);
        chk("rst_mresp1", mresp[1], '0);
        chk("rst_owner", owner, '0);
        resetn = 1'b1;

        // Tie straight after reset: dcache first, icache after one bubble.
        cyc();
        raise(0, 32'h1000_0040, 1'b0, MSIZE4, MLEN4, 4'hF);
        raise(1, 32'h2000_0100, 1'b0, MSIZE4, MLEN2, 4'hF);
        grant_q.push_back(0);
        grant_q.push_back(1);
        #1;
        chk("tie_latency", sreq.valid, 1'b0);
        cyc();
        serve(0, 1'b0);
        cyc();
        serve(0, 1'b0);

        // Alternation with both masters requesting back to back.
        cyc();
        raise(0, 32'h1000_0200, 1'b0, MSIZE4, MLEN2, 4'hF);
        raise(1, 32'h2000_0300, 1'b0, MSIZE4, MLEN1, 4'hF);
        for (int t = 0; t < 6; t++) grant_q.push_back(t % 2);
        #1;
        chk("alt_latency", sreq.valid, 1'b0);
        for (int t = 0; t < 6; t++) begin
            cyc();
            serve(0, t < 4);
        end

        // Single dcache read.
        cyc();
        raise(0, 32'h1000_0040, 1'b0, MSIZE4, MLEN4, 4'hF);
        grant_q.push_back(0);
        #1;
        chk("read_latency", sreq.valid, 1'b0);
        cyc();
        serve(0, 1'b0);

        // Write burst with wait cycles between beats.
        cyc();
        raise(0, 32'h1000_0080, 1'b1, MSIZE4, MLEN4, 4'hF);
        grant_q.push_back(0);
        cyc();
        serve(1, 1'b0);

        // Uncached single-byte write.
        cyc();
        raise(0, 32'h1FAF_F000, 1'b1, MSIZE1, MLEN1, 4'h2);
        wbeat[0] = 32'h0000_AB00;
        grant_q.push_back(0);
        cyc();
        serve(0, 1'b0);

        // Reset during beat 2 of an icache burst.
        cyc();
        raise(1, 32'h2000_0400, 1'b0, MSIZE4, MLEN4, 4'hF);
        cyc();
        sresp.ready = 1'b1; sresp.last = 1'b0; sresp.data = 32'hBEEF_0001;
        #1;
        chk("mid_beat1_ready", mresp[1].ready, 1'b1);
        chk("mid_beat1_owner", owner, 1'b1);
        cyc();
        resetn = 1'b0;
        sresp.data = 32'hBEEF_0002;
        #1;
        chk("mid_beat2_busy", busy, 1'b1);
        cyc();
        #1;
        chk("mid_rst_sreq_valid", sreq.valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        resetn = 1'b1;
        sresp  = '0;
        raise(0, 32'h1000_0500, 1'b0, MSIZE4, MLEN1, 4'hF);
        grant_q.push_back(0);
        grant_q.push_back(1);
        cyc();
        serve(0, 1'b0);
        cyc();
        serve(0, 1'b0);

        chk("grant_q_drained", 128'(grant_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
